// File: rtl/zion_basic_circuit_lib_write_dat_merge_if.sv
// ---------------------------------------------------------------------------
// zion_basic_circuit_lib_write_dat_merge_if
//
// Bundles the narrow write-beat input side and the wide line output side of
// the lane-merge buffer.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where the producer's valid and the consumer's ready are both 1.
// Beat channel: iVld (producer) / oRdy (buffer). Line channel: oVld (buffer)
// / iRdy (consumer). A valid never waits on its own ready.
//
//   iVld/iAddr/iDat/iFlush : narrow write beat into the buffer
//   oRdy                   : buffer can take a beat
//   oVld/oDat/oMask        : assembled line and its per-lane written mask
//   iRdy                   : downstream takes the line
//   oOvw/oErr              : one-cycle event pulses (lane overwrite, bad lane)
//
// modport master : the side driving beats and accepting lines
// modport slave  : the merge buffer
// ---------------------------------------------------------------------------
interface zion_basic_circuit_lib_write_dat_merge_if #(
   parameter int LANE_W     = 8,
   parameter int LANE_NUM   = 4,
   parameter int WIDTH_ADDR = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1
);
   logic                       iVld;
   logic                       oRdy;
   logic [WIDTH_ADDR-1:0]      iAddr;
   logic [LANE_W-1:0]          iDat;
   logic                       iFlush;
   logic                       oVld;
   logic                       iRdy;
   logic [LANE_NUM*LANE_W-1:0] oDat;
   logic [LANE_NUM-1:0]        oMask;
   logic                       oOvw;
   logic                       oErr;

   modport master (
      output iVld, iAddr, iDat, iFlush, iRdy,
      input  oRdy, oVld, oDat, oMask, oOvw, oErr
   );

   modport slave (
      input  iVld, iAddr, iDat, iFlush, iRdy,
      output oRdy, oVld, oDat, oMask, oOvw, oErr
   );
endinterface

// File: rtl/zion_basic_circuit_lib_write_dat_merge.sv
// ---------------------------------------------------------------------------
// zion_basic_circuit_lib_write_dat_merge
//
// Collects narrow lane-addressed write beats into one wide line of LANE_NUM
// lanes, tracking which lanes were written. The line is presented downstream
// once every lane has been written or a flush closes a partial line.
//
// Ports:
//   clk       : clock, everything on the rising edge
//   rst       : synchronous active-high reset, overrides all other inputs
//   bus       : slave side of the merge interface (beats in, lines out)
//   dbg_state : current FSM state (0 IDLE, 1 FILL, 2 FULL)
// ---------------------------------------------------------------------------
module zion_basic_circuit_lib_write_dat_merge #(
   parameter int LANE_W   = 8,
   parameter int LANE_NUM = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   zion_basic_circuit_lib_write_dat_merge_if.slave bus,
   output logic [1:0]                            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [LANE_NUM*LANE_W-1:0] dat_q, dat_d;
   logic [LANE_NUM-1:0]        mask_q, mask_d;
   logic                       ovw_q, ovw_d;
   logic                       err_q, err_d;

   logic                       accept;
   logic [LANE_NUM-1:0]        hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dat_q   <= '0;
         mask_q  <= '0;
         ovw_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dat_q   <= dat_d;
         mask_q  <= mask_d;
         ovw_q   <= ovw_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dat_d   = dat_q;
      mask_d  = mask_q;
      ovw_d   = 1'b0;
      err_d   = 1'b0;
      accept  = 1'b0;
      hit     = '0;

      case (state_q)
         S_FULL: begin
            // Inputs are not looked at while a line is held.
            if (bus.iRdy) begin
               state_d = S_IDLE;
               dat_d   = '0;
               mask_d  = '0;
            end
         end

         S_IDLE, S_FILL: begin
            accept = bus.iVld;
            // One-hot lane decode; an address past the last lane decodes to
            // nothing, which is exactly the "drop and flag" case.
            for (int j = 0; j < LANE_NUM; j++) begin
               hit[j] = accept && (int'(bus.iAddr) == j);
               if (hit[j]) begin
                  dat_d[j*LANE_W +: LANE_W] = bus.iDat;
                  mask_d[j]                 = 1'b1;
                  ovw_d                     = mask_q[j];
               end
            end
            err_d = accept && (hit == '0);

            // The same-cycle beat is merged before the flush is judged, so a
            // flush with a beat in IDLE still produces a one-lane line, while
            // a flush with nothing merged is silently dropped.
            if (&mask_d) begin
               state_d = S_FULL;
            end else if (|mask_d) begin
               state_d = bus.iFlush ? S_FULL : S_FILL;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            dat_d   = '0;
            mask_d  = '0;
         end
      endcase
   end

   assign bus.oRdy  = (state_q != S_FULL);
   assign bus.oVld  = (state_q == S_FULL);
   assign bus.oDat  = dat_q;
   assign bus.oMask = mask_q;
   assign bus.oOvw  = ovw_q;
   assign bus.oErr  = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_write_dat_merge.sv
// ---------------------------------------------------------------------------
// Bench for zion_basic_circuit_lib_write_dat_merge. Three instances are run
// side by side: 4 lanes, 3 lanes (reachable bad address) and 1 lane. A
// behavioural model (lane arrays plus a "line held" flag) predicts every
// output each cycle; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_zion_basic_circuit_lib_write_dat_merge;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // per-instance drive values
   logic       v[3];
   logic [1:0] a[3];
   logic [7:0] d[3];
   logic       f[3];
   logic       r[3];

   // per-instance observed outputs, zero-extended
   logic [31:0] o_dat[3];
   logic [3:0]  o_mask[3];
   logic        o_vld[3], o_rdy[3], o_ovw[3], o_err[3];
   logic [1:0]  o_dbg[3];

   zion_basic_circuit_lib_write_dat_merge_if #(.LANE_W(8), .LANE_NUM(4)) bus0 ();
   zion_basic_circuit_lib_write_dat_merge_if #(.LANE_W(8), .LANE_NUM(3)) bus1 ();
   zion_basic_circuit_lib_write_dat_merge_if #(.LANE_W(8), .LANE_NUM(1)) bus2 ();

   zion_basic_circuit_lib_write_dat_merge #(.LANE_W(8), .LANE_NUM(4)) u0 (
      .clk(clk), .rst(rst), .bus(bus0), .dbg_state(o_dbg[0]));
   zion_basic_circuit_lib_write_dat_merge #(.LANE_W(8), .LANE_NUM(3)) u1 (
      .clk(clk), .rst(rst), .bus(bus1), .dbg_state(o_dbg[1]));
   zion_basic_circuit_lib_write_dat_merge #(.LANE_W(8), .LANE_NUM(1)) u2 (
      .clk(clk), .rst(rst), .bus(bus2), .dbg_state(o_dbg[2]));

   assign bus0.iVld = v[0]; assign bus0.iAddr = a[0];    assign bus0.iDat = d[0];
   assign bus0.iFlush = f[0]; assign bus0.iRdy = r[0];
   assign bus1.iVld = v[1]; assign bus1.iAddr = a[1];    assign bus1.iDat = d[1];
   assign bus1.iFlush = f[1]; assign bus1.iRdy = r[1];
   assign bus2.iVld = v[2]; assign bus2.iAddr = a[2][0]; assign bus2.iDat = d[2];
   assign bus2.iFlush = f[2]; assign bus2.iRdy = r[2];

   assign o_dat[0] = bus0.oDat;          assign o_mask[0] = bus0.oMask;
   assign o_dat[1] = {8'h0, bus1.oDat};  assign o_mask[1] = {1'b0, bus1.oMask};
   assign o_dat[2] = {24'h0, bus2.oDat}; assign o_mask[2] = {3'b0, bus2.oMask};
   assign o_vld[0] = bus0.oVld; assign o_rdy[0] = bus0.oRdy;
   assign o_ovw[0] = bus0.oOvw; assign o_err[0] = bus0.oErr;
   assign o_vld[1] = bus1.oVld; assign o_rdy[1] = bus1.oRdy;
   assign o_ovw[1] = bus1.oOvw; assign o_err[1] = bus1.oErr;
   assign o_vld[2] = bus2.oVld; assign o_rdy[2] = bus2.oRdy;
   assign o_ovw[2] = bus2.oOvw; assign o_err[2] = bus2.oErr;

   // ---------------- reference model ----------------
   int         nl[3] = '{4, 3, 1};
   logic [7:0] m_lane[3][4];
   bit         m_wr[3][4];
   bit         m_held[3];
   bit         m_ovw[3], m_err[3];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear(input int k);
      for (int j = 0; j < 4; j++) begin
         m_lane[k][j] = 8'h00;
         m_wr[k][j]   = 1'b0;
      end
      m_held[k] = 1'b0;
   endtask

   // One clock edge of the buffer as the rules describe it.
   task automatic model_step(input int k);
      int cnt;
      m_ovw[k] = 1'b0;
      m_err[k] = 1'b0;
      if (rst) begin
         model_clear(k);
      end else if (m_held[k]) begin
         if (r[k]) model_clear(k);
      end else begin
         if (v[k]) begin
            if (int'(a[k]) < nl[k]) begin
               m_ovw[k]          = m_wr[k][a[k]];
               m_lane[k][a[k]]   = d[k];
               m_wr[k][a[k]]     = 1'b1;
            end else begin
               m_err[k] = 1'b1;
            end
         end
         cnt = 0;
         for (int j = 0; j < nl[k]; j++) if (m_wr[k][j]) cnt++;
         if (cnt == nl[k] || (f[k] && cnt > 0)) m_held[k] = 1'b1;
      end
   endtask

   task automatic check_all();
      logic [31:0] ed;
      logic [3:0]  em;
      int          cnt;
      for (int k = 0; k < 3; k++) begin
         ed  = '0;
         em  = '0;
         cnt = 0;
         for (int j = 0; j < nl[k]; j++) begin
            ed[j*8 +: 8] = m_lane[k][j];
            em[j]        = m_wr[k][j];
            if (m_wr[k][j]) cnt++;
         end
         chk($sformatf("vld%0d", k),  32'(o_vld[k]), 32'(m_held[k]));
         chk($sformatf("rdy%0d", k),  32'(o_rdy[k]), 32'(!m_held[k]));
         chk($sformatf("dat%0d", k),  o_dat[k], ed);
         chk($sformatf("mask%0d", k), 32'(o_mask[k]), 32'(em));
         chk($sformatf("ovw%0d", k),  32'(o_ovw[k]), 32'(m_ovw[k]));
         chk($sformatf("err%0d", k),  32'(o_err[k]), 32'(m_err[k]));
         chk($sformatf("state%0d", k), 32'(o_dbg[k]),
             m_held[k] ? 32'd2 : (cnt > 0 ? 32'd1 : 32'd0));
      end
   endtask

   // inputs are changed only at the falling edge, right after checking
   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      @(negedge clk);
      check_all();
   endtask

   task automatic quiet();
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0; a[k] = 2'd0; d[k] = 8'h00; f[k] = 1'b0; r[k] = 1'b0;
      end
   endtask

   task automatic beat0(input logic [1:0] addr, input logic [7:0] dat,
                        input logic flush, input logic rdy);
      quiet();
      v[0] = 1'b1; a[0] = addr; d[0] = dat; f[0] = flush; r[0] = rdy;
      tick();
   endtask

   task automatic idle0(input logic rdy, input logic flush);
      quiet();
      r[0] = rdy; f[0] = flush;
      tick();
   endtask

   initial begin
      quiet();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("reset_rdy", 32'(bus0.oRdy), 32'd1);
      chk("reset_dat", bus0.oDat, 32'h0);

      // fill in order
      beat0(2'd0, 8'h11, 1'b0, 1'b1);
      beat0(2'd1, 8'h22, 1'b0, 1'b1);
      beat0(2'd2, 8'h33, 1'b0, 1'b1);
      chk("fill_not_yet", 32'(bus0.oVld), 32'd0);
      beat0(2'd3, 8'h44, 1'b0, 1'b1);
      chk("fill_vld", 32'(bus0.oVld), 32'd1);
      chk("fill_dat", bus0.oDat, 32'h44332211);
      chk("fill_mask", 32'(bus0.oMask), 32'hF);
      idle0(1'b1, 1'b0);
      chk("fill_back_rdy", 32'(bus0.oRdy), 32'd1);

      // partial flush
      beat0(2'd2, 8'hAB, 1'b0, 1'b0);
      beat0(2'd0, 8'hCD, 1'b1, 1'b0);
      chk("pflush_dat", bus0.oDat, 32'h00AB00CD);
      chk("pflush_mask", 32'(bus0.oMask), 32'h5);
      chk("pflush_ovw", 32'(bus0.oOvw), 32'd0);
      idle0(1'b1, 1'b0);

      // overwrite and backpressure
      beat0(2'd1, 8'h10, 1'b0, 1'b0);
      beat0(2'd1, 8'h20, 1'b0, 1'b0);
      chk("ovw_pulse", 32'(bus0.oOvw), 32'd1);
      beat0(2'd0, 8'h01, 1'b0, 1'b0);
      chk("ovw_once", 32'(bus0.oOvw), 32'd0);
      beat0(2'd2, 8'h02, 1'b0, 1'b0);
      beat0(2'd3, 8'h03, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         quiet();
         v[0] = 1'b1; a[0] = 2'd0; d[0] = 8'hEE;   // ignored while held
         tick();
         chk("stall_dat", bus0.oDat, 32'h03022001);
         chk("stall_rdy", 32'(bus0.oRdy), 32'd0);
      end
      idle0(1'b1, 1'b0);

      // out-of-range lane on the 3-lane instance
      quiet();
      v[1] = 1'b1; a[1] = 2'd3; d[1] = 8'hFF;
      tick();
      chk("oor_err", 32'(bus1.oErr), 32'd1);
      chk("oor_mask", 32'(bus1.oMask), 32'd0);
      chk("oor_state", 32'(o_dbg[1]), 32'd0);

      // empty flush
      idle0(1'b0, 1'b1);
      idle0(1'b0, 1'b0);
      chk("eflush_vld", 32'(bus0.oVld), 32'd0);

      // reset mid-line, then a clean line
      beat0(2'd0, 8'hAA, 1'b0, 1'b0);
      beat0(2'd1, 8'hBB, 1'b0, 1'b0);
      quiet();
      v[0] = 1'b1; a[0] = 2'd2; d[0] = 8'hCC;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mask", 32'(bus0.oMask), 32'd0);
      chk("rst_dat", bus0.oDat, 32'd0);
      beat0(2'd3, 8'h04, 1'b0, 1'b0);
      beat0(2'd2, 8'h03, 1'b0, 1'b0);
      beat0(2'd1, 8'h02, 1'b0, 1'b0);
      beat0(2'd0, 8'h01, 1'b0, 1'b0);
      chk("post_rst_dat", bus0.oDat, 32'h04030201);
      idle0(1'b1, 1'b0);

      // single-lane instance
      quiet();
      v[2] = 1'b1; a[2] = 2'd0; d[2] = 8'h5A;
      tick();
      chk("one_vld", 32'(bus2.oVld), 32'd1);
      chk("one_mask", 32'(bus2.oMask), 32'd1);
      quiet();
      r[2] = 1'b1;
      tick();

      // random traffic on all three instances
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int k = 0; k < 3; k++) begin
            v[k] = ($urandom_range(0, 9) < 6);
            a[k] = 2'($urandom_range(0, (k == 2) ? 1 : 3));
            d[k] = 8'($urandom);
            f[k] = ($urandom_range(0, 9) < 2);
            r[k] = ($urandom_range(0, 9) < 5);
         end
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
